fetch_decode: RTL and testbench
===============================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have port CLOCK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port CLEAR, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port inst, input, 16 bits: instruction word from instruction memory for the current PC.
REQ-004 SHALL have port pc, input, 8 bits: PC value that fetched inst.
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag, used by BZ.
REQ-006 SHALL have port stall_in, input, 1 bit: external freeze request.
REQ-007 SHALL have port mem_ready, input, 1 bit: data-memory completion strobe.
REQ-008 SHALL have port ctrl, output, 1 bit: PC mux select; 1 = br_addr, 0 = incremented PC.
REQ-009 SHALL have port br_addr, output, 8 bits: branch/jump target.
REQ-010 SHALL have port pc_en, output, 1 bit: 1 = PC may advance, 0 = PC hold.
REQ-011 SHALL have port mem_req, output, 1 bit: data-memory request for LOAD/STORE.
REQ-012 SHALL have ports id_valid (1), id_op (4), id_rd (4), id_rs (4), id_rt (4), id_imm (8) and id_pc (8), all outputs: IF/ID register contents.

Function
REQ-013 SHALL decode the format as op = inst[15:12], rd = [11:8], rs = [7:4], rt = [3:0], imm = [7:0].
REQ-014 SHALL use opcodes 0x0 NOP, 0x1-0x7 ALU, 0x8 LOAD, 0x9 STORE, 0xA BZ, 0xB JMP, and 0xF HALT; 0xC-0xE SHALL be treated as NOP.
REQ-015 SHALL implement FSM states RUN, WAIT_MEM and HALTED.
REQ-016 SHALL capture inst/pc into IF/ID and set id_valid=1 on each edge where advance is true; advance = state RUN && !stall_in && !(mem op in ID && !mem_ready).
REQ-017 SHALL compute ctrl combinationally as id_valid && RUN && !stall_in && (op==JMP || (op==BZ && zero)).
REQ-018 SHALL drive br_addr = id_imm (absolute target).
REQ-019 SHALL, when ctrl=1, set id_valid=0 on the same edge (one-bubble flush of the wrong-path instruction).
REQ-020 SHALL drive mem_req = id_valid && (op==LOAD || op==STORE) && state is RUN or WAIT_MEM.
REQ-021 SHALL transition RUN -> WAIT_MEM when mem_req && !mem_ready && !stall_in.
REQ-022 SHALL transition WAIT_MEM -> RUN on mem_ready, advancing the same edge.
REQ-023 SHALL hold pc_en=0 in WAIT_MEM and IF/ID unchanged while there.
REQ-024 SHALL drive pc_en = advance.
REQ-025 SHALL, when stall_in=1, freeze state, IF/ID and outputs with ctrl=0 and pc_en=0; stall SHALL win over a simultaneous branch, which is re-evaluated after release.
REQ-026 SHALL ignore ctrl and mem_req for invalid (bubble) entries.

Reset
REQ-027 SHALL, while CLEAR=1, immediately force state RUN, id_valid=0, all id_* fields=0, ctrl=0, mem_req=0 and pc_en=0.
REQ-028 SHALL, on CLEAR asserted mid-WAIT_MEM or in HALTED, abandon the pending operation with no request retained.
REQ-029 SHALL advance on the first rising edge after CLEAR falls.

Configuration
REQ-030 SHALL, with FETCH_DECODE_HALT_EN defined, enter HALTED when valid op 0xF reaches ID and not stalled; HALTED SHALL hold pc_en=0 and ctrl=0, and exit only via CLEAR.
REQ-031 SHALL, with FETCH_DECODE_HALT_EN undefined, treat 0xF as NOP and never reach HALTED.

Structure
REQ-032 SHALL keep opcode constants and FSM state encodings in a shared package, fetch_decode_pkg, for reuse by the execute stage.
REQ-033 SHALL contain exactly one sub-module, ifid_reg (IF/ID pipeline register with load enable and flush); FSM and branch logic SHALL remain in fetch_decode.

Verification
REQ-034 SHALL cover reset: CLEAR=1 mid-run -> id_valid=0, ctrl=0 and pc_en=0 without a clock edge; first fetch after release is pc=0x00.
REQ-035 SHALL cover JMP: inst=0xB042 at pc=0x05 -> next cycle ctrl=1, br_addr=0x42, following ID slot id_valid=0.
REQ-036 SHALL cover BZ: inst=0xA010 with zero=0 -> ctrl=0 and sequential flow; with zero=1 -> ctrl=1 and br_addr=0x10.
REQ-037 SHALL cover LOAD wait: inst=0x8123 with mem_ready low 3 cycles -> mem_req=1 and pc_en=0 for 3 cycles, advance on the cycle mem_ready=1.
REQ-038 SHALL cover stall priority: stall_in=1 while JMP is in ID -> ctrl=0 and IF/ID held; after release, ctrl=1 for one cycle.
REQ-039 SHALL cover HALT: inst=0xF000 -> pc_en=0 permanently with FETCH_DECODE_HALT_EN defined; behaves as NOP without it.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// fetch_decode_pkg: opcode constants, FSM state encoding, IF/ID record and
// small decode helpers shared between the fetch/decode and execute stages.
package fetch_decode_pkg;

    // Opcode map (inst[15:12]); 0xC-0xE are reserved and decode as NOP.
    localparam logic [3:0] OpNop    = 4'h0;
    localparam logic [3:0] OpAluLo  = 4'h1;
    localparam logic [3:0] OpAluHi  = 4'h7;
    localparam logic [3:0] OpLoad   = 4'h8;
    localparam logic [3:0] OpStore  = 4'h9;
    localparam logic [3:0] OpBz     = 4'hA;
    localparam logic [3:0] OpJmp    = 4'hB;
    localparam logic [3:0] OpHalt   = 4'hF;

    // Front-end control FSM
    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StWaitMem = 2'b01,
        StHalted  = 2'b10
    } fd_state_e;

    // Decoded IF/ID pipeline register contents
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [7:0] imm;
        logic [7:0] pc;
    } ifid_t;

    // Split a raw instruction word into its fields; imm overlaps rs/rt.
    function automatic ifid_t decode_inst(input logic [15:0] inst, input logic [7:0] pc);
        ifid_t d;
        d.op  = inst[15:12];
        d.rd  = inst[11:8];
        d.rs  = inst[7:4];
        d.rt  = inst[3:0];
        d.imm = inst[7:0];
        d.pc  = pc;
        return d;
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OpLoad) || (op == OpStore);
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OpAluLo) && (op <= OpAluHi);
    endfunction

    // True when the instruction redirects the PC given the current zero flag.
    function automatic logic is_branch_taken(input logic [3:0] op, input logic zero);
        return (op == OpJmp) || ((op == OpBz) && zero);
    endfunction

    function automatic logic is_halt_op(input logic [3:0] op);
        return op == OpHalt;
    endfunction

endpackage

// File: rtl/fetch_decode_ifid_reg.sv
// ifid_reg: IF/ID pipeline register. Loads the decoded instruction when
// i_load is high; i_flush marks the captured entry as a bubble.
module ifid_reg
    import fetch_decode_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [15:0] i_inst,
    input  logic [7:0]  i_pc,
    output logic        o_valid,
    output ifid_t       o_id
);

    logic  r_valid;
    ifid_t r_id;
    ifid_t w_decoded;

    assign w_decoded = decode_inst(i_inst, i_pc);

    // Capture on load; a flush on the same edge turns the new entry into a bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_id    <= '0;
        end else if (i_load) begin
            r_id    <= w_decoded;
            r_valid <= ~i_flush;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_id    = r_id;

endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: fetch/decode front end. Holds the IF/ID register, steers the
// PC mux for JMP/BZ, stalls on data-memory handshakes and external freeze.
// Optional feature: define FETCH_DECODE_HALT_EN to make opcode 0xF halt the
// front end until CLEAR; otherwise 0xF is a NOP.
module fetch_decode
    import fetch_decode_pkg::*;
(
    input  logic        CLOCK,
    input  logic        CLEAR,
    input  logic [15:0] inst,
    input  logic [7:0]  pc,
    input  logic        zero,
    input  logic        stall_in,
    input  logic        mem_ready,
    output logic        ctrl,
    output logic [7:0]  br_addr,
    output logic        pc_en,
    output logic        mem_req,
    output logic        id_valid,
    output logic [3:0]  id_op,
    output logic [3:0]  id_rd,
    output logic [3:0]  id_rs,
    output logic [3:0]  id_rt,
    output logic [7:0]  id_imm,
    output logic [7:0]  id_pc
);

    fd_state_e r_state;
    fd_state_e w_state_next;

    logic  w_valid;
    ifid_t w_id;
    logic  w_id_mem;
    logic  w_id_taken;
    logic  w_id_halt;
    logic  w_advance;
    logic  w_ctrl;
    logic  w_mem_req;

    ifid_reg u_ifid_reg (
        .i_clk   (CLOCK),
        .i_rst   (CLEAR),
        .i_load  (w_advance),
        .i_flush (w_ctrl),
        .i_inst  (inst),
        .i_pc    (pc),
        .o_valid (w_valid),
        .o_id    (w_id)
    );

    // Bubbles never request memory, branch or halt.
    assign w_id_mem   = w_valid && is_mem_op(w_id.op);
    assign w_id_taken = w_valid && is_branch_taken(w_id.op, zero);
`ifdef FETCH_DECODE_HALT_EN
    assign w_id_halt  = w_valid && is_halt_op(w_id.op);
`else
    assign w_id_halt  = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, advance, PC-mux select and memory request
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        w_ctrl       = 1'b0;
        w_mem_req    = 1'b0;

        case (r_state)
            StRun: begin
                w_mem_req = w_id_mem;
                if (!stall_in) begin
                    w_ctrl    = w_id_taken;
                    w_advance = !(w_id_mem && !mem_ready);
                    if (w_id_mem && !mem_ready) begin
                        w_state_next = StWaitMem;
                    end else if (w_id_halt) begin
                        w_state_next = StHalted;
                    end
                end
            end
            StWaitMem: begin
                w_mem_req = w_id_mem;
                // Completion releases the pipeline on the same edge.
                if (!stall_in && mem_ready) begin
                    w_advance    = 1'b1;
                    w_state_next = StRun;
                end
            end
            StHalted: begin
`ifdef FETCH_DECODE_HALT_EN
                w_state_next = StHalted;
`else
                w_state_next = StRun;
`endif
            end
            default: begin
                w_state_next = StRun;
            end
        endcase

        // Outputs drop immediately on reset, without waiting for an edge.
        if (CLEAR) begin
            w_advance = 1'b0;
            w_ctrl    = 1'b0;
            w_mem_req = 1'b0;
        end
    end

    assign ctrl     = w_ctrl;
    assign br_addr  = w_id.imm;
    assign pc_en    = w_advance;
    assign mem_req  = w_mem_req;
    assign id_valid = w_valid;
    assign id_op    = w_id.op;
    assign id_rd    = w_id.rd;
    assign id_rs    = w_id.rs;
    assign id_rt    = w_id.rt;
    assign id_imm   = w_id.imm;
    assign id_pc    = w_id.pc;

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed scenario tasks plus a randomized program run
// checked against a behavioural model of the fetch/decode front end.
module tb_fetch_decode;

    logic        CLOCK;
    logic        CLEAR;
    logic [15:0] inst;
    logic [7:0]  pc;
    logic        zero;
    logic        stall_in;
    logic        mem_ready;
    logic        ctrl;
    logic [7:0]  br_addr;
    logic        pc_en;
    logic        mem_req;
    logic        id_valid;
    logic [3:0]  id_op;
    logic [3:0]  id_rd;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic [7:0]  id_imm;
    logic [7:0]  id_pc;

    int checks = 0;
    int errors = 0;

    fetch_decode dut (
        .CLOCK     (CLOCK),
        .CLEAR     (CLEAR),
        .inst      (inst),
        .pc        (pc),
        .zero      (zero),
        .stall_in  (stall_in),
        .mem_ready (mem_ready),
        .ctrl      (ctrl),
        .br_addr   (br_addr),
        .pc_en     (pc_en),
        .mem_req   (mem_req),
        .id_valid  (id_valid),
        .id_op     (id_op),
        .id_rd     (id_rd),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_imm    (id_imm),
        .id_pc     (id_pc)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Land 1 time unit after the rising edge; inputs change here.
    task automatic next_cycle();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic drive(input logic [15:0] i, input logic [7:0] p);
        inst = i;
        pc   = p;
    endtask

    task automatic pulse_clear();
        CLEAR = 1'b1;
        next_cycle();
        CLEAR = 1'b0;
        stall_in = 1'b0;
        mem_ready = 1'b1;
        zero = 1'b0;
    endtask

    task automatic test_reset();
        CLEAR = 1'b1; stall_in = 1'b0; mem_ready = 1'b1; zero = 1'b0;
        drive(16'h0000, 8'h00);
        #2;
        checks++; if (id_valid !== 1'b0) begin errors++;
            $display("FAIL rst_valid got %b want 0", id_valid); end
        checks++; if (pc_en !== 1'b0) begin errors++;
            $display("FAIL rst_pc_en got %b want 0", pc_en); end
        checks++; if ({id_op, id_imm, id_pc} !== 20'h0) begin errors++;
            $display("FAIL rst_fields got %h want 0", {id_op, id_imm, id_pc}); end
        next_cycle();
        CLEAR = 1'b0;
        drive(16'h1234, 8'h00);
        #2;
        checks++; if (pc_en !== 1'b1) begin errors++;
            $display("FAIL rel_pc_en got %b want 1", pc_en); end
        next_cycle();
        checks++; if ({id_valid, id_pc, id_op, id_rd, id_rs, id_rt} !== 25'h1_00_1234) begin
            errors++; $display("FAIL first_fetch got %h want 1001234",
                {id_valid, id_pc, id_op, id_rd, id_rs, id_rt}); end
        drive(16'hB099, 8'h01);
        next_cycle();
        drive(16'h0000, 8'h02);
        #1;
        checks++; if (ctrl !== 1'b1) begin errors++;
            $display("FAIL pre_clear_ctrl got %b want 1", ctrl); end
        CLEAR = 1'b1;
        #1;
        checks++; if ({id_valid, ctrl, pc_en, mem_req} !== 4'b0000) begin errors++;
            $display("FAIL async_clear got %b want 0000", {id_valid, ctrl, pc_en, mem_req}); end
        next_cycle();
        CLEAR = 1'b0;
        drive(16'h0000, 8'h00);
        #2;
        checks++; if (pc_en !== 1'b1) begin errors++;
            $display("FAIL rel2_pc_en got %b want 1", pc_en); end
        next_cycle();
        checks++; if ({id_valid, id_pc} !== 9'h100) begin errors++;
            $display("FAIL refetch got %h want 100", {id_valid, id_pc}); end
    endtask

    task automatic test_jmp();
        drive(16'hB042, 8'h05);
        next_cycle();
        drive(16'h1234, 8'h06);
        #2;
        checks++; if ({ctrl, br_addr} !== 9'h142) begin errors++;
            $display("FAIL jmp_ctrl got %h want 142", {ctrl, br_addr}); end
        next_cycle();
        drive(16'h2000, 8'h42);
        #2;
        checks++; if ({id_valid, ctrl} !== 2'b00) begin errors++;
            $display("FAIL jmp_bubble got %b want 00", {id_valid, ctrl}); end
        next_cycle();
        checks++; if ({id_valid, id_pc} !== 9'h142) begin errors++;
            $display("FAIL jmp_target got %h want 142", {id_valid, id_pc}); end
    endtask

    task automatic test_bz();
        drive(16'hA010, 8'h10);
        next_cycle();
        zero = 1'b0;
        drive(16'h1111, 8'h11);
        #2;
        checks++; if ({ctrl, pc_en} !== 2'b01) begin errors++;
            $display("FAIL bz_nt got %b want 01", {ctrl, pc_en}); end
        next_cycle();
        checks++; if ({id_valid, id_pc} !== 9'h111) begin errors++;
            $display("FAIL bz_seq got %h want 111", {id_valid, id_pc}); end
        drive(16'hA010, 8'h12);
        next_cycle();
        zero = 1'b1;
        drive(16'h1111, 8'h13);
        #2;
        checks++; if ({ctrl, br_addr} !== 9'h110) begin errors++;
            $display("FAIL bz_taken got %h want 110", {ctrl, br_addr}); end
        next_cycle();
        zero = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++;
            $display("FAIL bz_flush got %b want 0", id_valid); end
    endtask

    task automatic test_load();
        drive(16'h8123, 8'h20);
        next_cycle();
        drive(16'h0000, 8'h21);
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if ({mem_req, pc_en, id_pc} !== 10'h220) begin errors++;
                $display("FAIL load_wait%0d got %h want 220", c, {mem_req, pc_en, id_pc}); end
            next_cycle();
        end
        mem_ready = 1'b1;
        #2;
        checks++; if ({mem_req, pc_en} !== 2'b11) begin errors++;
            $display("FAIL load_done got %b want 11", {mem_req, pc_en}); end
        checks++; if ({id_rd, id_rs, id_rt, id_imm} !== 20'h12323) begin errors++;
            $display("FAIL load_fields got %h want 12323", {id_rd, id_rs, id_rt, id_imm}); end
        next_cycle();
        checks++; if ({id_pc, mem_req, pc_en} !== 10'h085) begin errors++;
            $display("FAIL load_next got %h want 085", {id_pc, mem_req, pc_en}); end
        // Clear while waiting on memory drops the request entirely.
        drive(16'h9456, 8'h30);
        next_cycle();
        mem_ready = 1'b0;
        drive(16'h0000, 8'h31);
        next_cycle();
        pulse_clear();
        drive(16'h0000, 8'h00);
        #2;
        checks++; if ({mem_req, pc_en} !== 2'b01) begin errors++;
            $display("FAIL clear_wait got %b want 01", {mem_req, pc_en}); end
        next_cycle();
    endtask

    task automatic test_stall();
        drive(16'hB077, 8'h40);
        next_cycle();
        drive(16'h0000, 8'h41);
        stall_in = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++; if ({ctrl, pc_en} !== 2'b00) begin errors++;
                $display("FAIL stall_out%0d got %b want 00", c, {ctrl, pc_en}); end
            next_cycle();
            checks++; if ({id_valid, id_op, id_pc} !== 13'h1B40) begin errors++;
                $display("FAIL stall_hold%0d got %h want 1b40", c, {id_valid, id_op, id_pc}); end
        end
        stall_in = 1'b0;
        #2;
        checks++; if ({ctrl, br_addr} !== 9'h177) begin errors++;
            $display("FAIL stall_rel got %h want 177", {ctrl, br_addr}); end
        next_cycle();
        drive(16'h0000, 8'h77);
        #2;
        checks++; if ({id_valid, ctrl} !== 2'b00) begin errors++;
            $display("FAIL stall_once got %b want 00", {id_valid, ctrl}); end
        next_cycle();
    endtask

    task automatic test_halt();
        drive(16'hF000, 8'h50);
        next_cycle();
        drive(16'hB055, 8'h51);
        #2;
        checks++; if (pc_en !== 1'b1) begin errors++;
            $display("FAIL halt_enter got %b want 1", pc_en); end
        next_cycle();
        drive(16'h0000, 8'h52);
        for (int c = 0; c < 4; c++) begin
            #2;
`ifdef FETCH_DECODE_HALT_EN
            checks++; if ({ctrl, pc_en, id_pc} !== 10'h051) begin errors++;
                $display("FAIL halted%0d got %h want 051", c, {ctrl, pc_en, id_pc}); end
`else
            checks++; if (pc_en !== 1'b1) begin errors++;
                $display("FAIL halt_nop%0d got %b want 1", c, pc_en); end
`endif
            next_cycle();
        end
        pulse_clear();
    endtask

    task automatic test_random();
        logic [15:0] imem [256];
        logic        m_valid;
        logic        m_wait;
        logic [15:0] m_inst;
        logic [7:0]  m_idpc;
        logic [7:0]  m_pc;
        logic [7:0]  tgt;
        logic [3:0]  op;
        logic        is_mem;
        logic        e_ctrl;
        logic        e_adv;
        for (int a = 0; a < 256; a++) begin
            imem[a] = {4'($urandom_range(0, 14)), 12'($urandom)};
        end
        pulse_clear();
        m_valid = 1'b0; m_wait = 1'b0; m_inst = 16'h0; m_idpc = 8'h0; m_pc = 8'h0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            zero      = 1'($urandom_range(0, 1));
            stall_in  = ($urandom_range(0, 4) == 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            drive(imem[m_pc], m_pc);
            #2;
            op     = m_inst[15:12];
            tgt    = m_inst[7:0];
            is_mem = m_valid && (op == 4'h8 || op == 4'h9);
            e_ctrl = m_valid && !m_wait && !stall_in && (op == 4'hB || (op == 4'hA && zero));
            e_adv  = !stall_in && (m_wait ? mem_ready : !(is_mem && !mem_ready));
            checks++; if ({ctrl, mem_req, pc_en, id_valid} !== {e_ctrl, is_mem, e_adv, m_valid})
            begin errors++; $display("FAIL rnd_ctl cyc %0d got %b want %b", cyc,
                {ctrl, mem_req, pc_en, id_valid}, {e_ctrl, is_mem, e_adv, m_valid}); end
            if (m_valid) begin
                checks++; if ({id_pc, id_op, id_rd, id_rs, id_rt, br_addr} !== {m_idpc, m_inst, tgt})
                begin errors++; $display("FAIL rnd_id cyc %0d got %h want %h", cyc,
                    {id_pc, id_op, id_rd, id_rs, id_rt, br_addr}, {m_idpc, m_inst, tgt}); end
            end
            if (!stall_in) begin
                if (m_wait && mem_ready) m_wait = 1'b0;
                else if (!m_wait && is_mem && !mem_ready) m_wait = 1'b1;
            end
            if (e_adv) begin
                m_inst  = inst;
                m_idpc  = pc;
                m_valid = !e_ctrl;
            end
            m_pc = e_ctrl ? tgt : (e_adv ? m_pc + 8'd1 : m_pc);
            next_cycle();
        end
        stall_in = 1'b0;
        mem_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_jmp();
        test_bz();
        test_load();
        test_stall();
        test_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
